// File: rtl/step_clock_ctrl_pkg.sv
// Shared definitions for the step clock controller: FSM state encoding and
// default build constants.
package step_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } step_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;
  localparam int unsigned DEFAULT_COUNT_W         = 32'd32;

endpackage

// File: rtl/step_clock_ctrl_if.sv
// Board-side bundle of the step clock controller: divider, button, switch and
// CPU halt in; step pulse, step count and status out.
interface step_clock_ctrl_if
  import step_clock_pkg::*;
#(
  parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) ();

  logic               DividedClock;
  logic               StepButton;
  logic               RunMode;
  logic               Halt;
  logic               CpuEnable;
  logic [COUNT_W-1:0] StepCount;
  logic               Running;
  logic               Halted;

  modport master (
    output DividedClock, StepButton, RunMode, Halt,
    input  CpuEnable, StepCount, Running, Halted
  );

  modport slave (
    input  DividedClock, StepButton, RunMode, Halt,
    output CpuEnable, StepCount, Running, Halted
  );

endinterface

// File: rtl/step_clock_ctrl_button_debouncer.sv
// Two-flop synchronizer plus counter debouncer for a raw push-button; emits a
// one-cycle press pulse on each debounced 0->1 transition.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic button,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] count;

  // The counter only advances while the synchronized input disagrees with the stable value
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= button;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == stable) begin
        count <= '0;
      end else if (count == CNT_MAX) begin
        stable <= ~stable;
        count  <= '0;
        press  <= ~stable;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_clock_ctrl.sv
// Turns divider ticks or debounced step presses into single-cycle CPU enable
// pulses, with auto-run / single-step modes, halt handling and a step counter.
module step_clock_ctrl
  import step_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned COUNT_W         = DEFAULT_COUNT_W
) (
  input  logic               Clock,
  input  logic               Reset,
  step_clock_ctrl_if.slave   bus
);

  logic               div_sync_1;
  logic               div_sync_2;
  logic               div_prev;
  logic               mode_sync_1;
  logic               mode_sync_2;
  logic               tick;
  logic               press;
  step_state_e        state;
  step_state_e        state_next;
  logic               pulse_next;
  logic               cpu_enable;
  logic [COUNT_W-1:0] step_count;
  logic               running;
  logic               halted;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .Clock (Clock),
    .Reset (Reset),
    .button(bus.StepButton),
    .press (press)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_sync_1  <= 1'b0;
      div_sync_2  <= 1'b0;
      div_prev    <= 1'b0;
      mode_sync_1 <= 1'b0;
      mode_sync_2 <= 1'b0;
    end else begin
      div_sync_1  <= bus.DividedClock;
      div_sync_2  <= div_sync_1;
      div_prev    <= div_sync_2;
      mode_sync_1 <= bus.RunMode;
      mode_sync_2 <= mode_sync_1;
    end
  end

  assign tick = div_sync_2 & ~div_prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Halt outranks a mode change, which outranks a pulse; halted drops events
  always_comb begin
    state_next = state;
    pulse_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Halt) begin
          state_next = ST_HALTED;
        end else if (mode_sync_2) begin
          state_next = ST_RUN;
        end else begin
          pulse_next = press;
        end
      end
      ST_RUN: begin
        if (bus.Halt) begin
          state_next = ST_HALTED;
        end else if (!mode_sync_2) begin
          state_next = ST_IDLE;
        end else begin
          pulse_next = tick;
        end
      end
      ST_HALTED: begin
        if (!bus.Halt) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_HALTED;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cpu_enable <= 1'b0;
      step_count <= '0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      cpu_enable <= pulse_next;
      if (pulse_next) begin
        step_count <= step_count + COUNT_W'(1);
      end else begin
        step_count <= step_count;
      end
      running <= (state_next == ST_RUN);
      halted  <= (state_next == ST_HALTED);
    end
  end

  assign bus.CpuEnable = cpu_enable;
  assign bus.StepCount = step_count;
  assign bus.Running   = running;
  assign bus.Halted    = halted;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Self-checking bench for step_clock_ctrl: scenario table, directed corner
// sequences and randomized stimulus against a history-based reference model.
module tb_step_clock_ctrl;

  localparam int N = 4;

  logic Clock = 1'b0;
  logic Reset;

  step_clock_ctrl_if #(.COUNT_W(32)) bus ();

  step_clock_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .COUNT_W        (32)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Histories of inputs sampled at each rising edge; index 1 is what the
  // two-flop synchronizer presents at the current edge.
  bit          hd[0:7];
  bit          hm[0:7];
  bit          hb[0:7];
  int          m_state = 0;   // 0 idle, 1 run, 2 halted
  bit          m_stable = 1'b0;
  bit          m_pend = 1'b0;
  bit          e_en = 1'b0;
  bit          e_run = 1'b0;
  bit          e_halt = 1'b0;
  logic [31:0] e_cnt = 32'd0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      hd[i] = 1'b0; hm[i] = 1'b0; hb[i] = 1'b0;
    end
    m_state = 0; m_stable = 1'b0; m_pend = 1'b0;
    e_en = 1'b0; e_run = 1'b0; e_halt = 1'b0; e_cnt = 32'd0;
  endtask

  task automatic model_step();
    bit tick, mode, press, flip, pulse;
    int nxt;
    tick  = hd[1] && !hd[2];
    mode  = hm[1];
    press = m_pend;
    flip  = 1'b1;
    for (int j = 1; j <= N; j++) if (hb[j] == m_stable) flip = 1'b0;
    pulse = 1'b0;
    nxt   = m_state;
    if (m_state == 2) begin
      if (!bus.Halt) nxt = 0;
    end else if (bus.Halt) nxt = 2;
    else if (m_state == 1 && !mode) nxt = 0;
    else if (m_state == 0 && mode) nxt = 1;
    else pulse = (m_state == 1) ? tick : press;
    e_en    = pulse;
    e_cnt   = e_cnt + 32'(pulse);
    m_state = nxt;
    e_run   = (nxt == 1);
    e_halt  = (nxt == 2);
    m_pend  = flip && !m_stable;
    if (flip) m_stable = !m_stable;
    for (int i = 7; i > 0; i--) begin
      hd[i] = hd[i-1]; hm[i] = hm[i-1]; hb[i] = hb[i-1];
    end
    hd[0] = bus.DividedClock; hm[0] = bus.RunMode; hb[0] = bus.StepButton;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  end

  // Continuous comparison against the model, away from the active edge
  initial forever begin
    @(negedge Clock);
    check("cpu_enable", {31'd0, bus.CpuEnable}, {31'd0, e_en});
    check("step_count", bus.StepCount, e_cnt);
    check("running",    {31'd0, bus.Running}, {31'd0, e_run});
    check("halted",     {31'd0, bus.Halted},  {31'd0, e_halt});
  end

  initial forever begin
    @(posedge Clock);
    #1;
    if (bus.CpuEnable === 1'b1) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic div_edges(input int n, input int half);
    repeat (n) begin
      bus.DividedClock = 1'b1;
      cycles(half);
      bus.DividedClock = 1'b0;
      cycles(half);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cpu_enable"}, {31'd0, bus.CpuEnable}, 32'd0);
    check({tag, "_step_count"}, bus.StepCount, 32'd0);
    check({tag, "_running"},    {31'd0, bus.Running}, 32'd0);
    check({tag, "_halted"},     {31'd0, bus.Halted},  32'd0);
  endtask

  typedef struct {
    bit run_mode;
    bit halt;
    int edges;
    int exp_pulses;
    bit exp_running;
    bit exp_halted;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p0;
    bit lat_exp[1:4];

    vecs[0] = '{run_mode: 1'b1, halt: 1'b0, edges: 5, exp_pulses: 5, exp_running: 1'b1, exp_halted: 1'b0};
    vecs[1] = '{run_mode: 1'b0, halt: 1'b0, edges: 5, exp_pulses: 0, exp_running: 1'b0, exp_halted: 1'b0};
    vecs[2] = '{run_mode: 1'b1, halt: 1'b1, edges: 4, exp_pulses: 0, exp_running: 1'b0, exp_halted: 1'b1};
    vecs[3] = '{run_mode: 1'b0, halt: 1'b1, edges: 3, exp_pulses: 0, exp_running: 1'b0, exp_halted: 1'b1};

    Reset = 1'b1;
    bus.DividedClock = 1'b0;
    bus.StepButton   = 1'b0;
    bus.RunMode      = 1'b0;
    bus.Halt         = 1'b0;
    cycles(3);
    check_zero_outputs("reset");
    Reset = 1'b0;
    step();
    check("first_cycle_no_pulse", {31'd0, bus.CpuEnable}, 32'd0);

    // Scenario table
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bus.RunMode = vecs[v].run_mode;
      bus.Halt    = vecs[v].halt;
      cycles(6);
      p0 = pulses;
      div_edges(vecs[v].edges, 10);
      cycles(5);
      check("tbl_pulses",     32'(pulses - p0), 32'(vecs[v].exp_pulses));
      check("tbl_step_count", bus.StepCount, 32'(vecs[v].exp_pulses));
      check("tbl_running",    {31'd0, bus.Running}, {31'd0, vecs[v].exp_running});
      check("tbl_halted",     {31'd0, bus.Halted},  {31'd0, vecs[v].exp_halted});
      bus.Halt = 1'b0;
    end

    // Tick latency: pulse during the cycle after edge k+2
    lat_exp[1] = 1'b0; lat_exp[2] = 1'b0; lat_exp[3] = 1'b1; lat_exp[4] = 1'b0;
    do_reset();
    bus.RunMode = 1'b1;
    cycles(6);
    bus.DividedClock = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("tick_latency", {31'd0, bus.CpuEnable}, {31'd0, lat_exp[i]});
    end
    bus.DividedClock = 1'b0;
    cycles(10);

    // Bouncy button in single-step mode
    do_reset();
    bus.RunMode = 1'b0;
    cycles(6);
    bus.StepButton = 1'b1; step();
    bus.StepButton = 1'b0; step();
    bus.StepButton = 1'b1; step();
    bus.StepButton = 1'b0; step();
    bus.StepButton = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("press_latency", {31'd0, bus.CpuEnable}, (i == 7) ? 32'd1 : 32'd0);
    end
    p0 = pulses;
    cycles(100);
    check("hold_no_repeat", 32'(pulses - p0), 32'd0);
    bus.StepButton = 1'b0;
    cycles(10);

    // Halt coinciding with a tick in RUN
    do_reset();
    bus.RunMode = 1'b1;
    cycles(6);
    p0 = pulses;
    bus.DividedClock = 1'b1;
    step();
    step();
    bus.Halt = 1'b1;
    cycles(4);
    check("halt_tick_halted", {31'd0, bus.Halted}, 32'd1);
    bus.DividedClock = 1'b0;
    cycles(5);
    div_edges(2, 10);
    check("halt_no_pulses", 32'(pulses - p0), 32'd0);
    bus.Halt = 1'b0;
    step();
    check("unhalt_running", {31'd0, bus.Running}, 32'd0);
    check("unhalt_halted",  {31'd0, bus.Halted},  32'd0);
    cycles(3);

    // Mode switch after the third tick, then a button step
    do_reset();
    bus.RunMode = 1'b1;
    cycles(6);
    p0 = pulses;
    div_edges(3, 10);
    bus.RunMode = 1'b0;
    cycles(4);
    div_edges(3, 10);
    check("mode_switch_pulses", 32'(pulses - p0), 32'd3);
    bus.StepButton = 1'b1;
    cycles(12);
    bus.StepButton = 1'b0;
    cycles(10);
    check("mode_switch_press", 32'(pulses - p0), 32'd4);
    check("mode_switch_count", bus.StepCount, 32'd4);

    // Counter wrap
    step();
    dut.step_count = 32'hFFFF_FFFF;
    e_cnt = 32'hFFFF_FFFF;
    step();
    bus.StepButton = 1'b1;
    cycles(12);
    bus.StepButton = 1'b0;
    cycles(10);
    check("wrap_count", bus.StepCount, 32'd0);

    // Reset in the middle of a debounce (counter at 2)
    bus.StepButton = 1'b1;
    cycles(4);
    #1;
    Reset = 1'b1;
    #1;
    check_zero_outputs("rst_debounce");
    step();
    Reset = 1'b0;
    p0 = pulses;
    cycles(6);
    check("rst_debounce_no_early", 32'(pulses - p0), 32'd0);
    cycles(4);
    check("rst_debounce_full_press", 32'(pulses - p0), 32'd1);
    bus.StepButton = 1'b0;
    cycles(10);

    // Reset during a CpuEnable cycle
    bus.StepButton = 1'b1;
    cycles(7);
    check("pre_reset_pulse", {31'd0, bus.CpuEnable}, 32'd1);
    #1;
    Reset = 1'b1;
    bus.StepButton = 1'b0;
    #1;
    check_zero_outputs("rst_pulse");
    step();
    Reset = 1'b0;
    p0 = pulses;
    cycles(20);
    check("rst_pulse_quiet", 32'(pulses - p0), 32'd0);

    // Randomized stimulus against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(7) == 0)   bus.DividedClock = ~bus.DividedClock;
      if ($urandom_range(5) == 0)   bus.StepButton   = ~bus.StepButton;
      if ($urandom_range(199) == 0) bus.RunMode      = ~bus.RunMode;
      if ($urandom_range(99) == 0)  bus.Halt         = ~bus.Halt;
    end
    cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
